// File: rtl/modulo_1_pkg.sv
// modulo_1_pkg: shared types and the E logic-function evaluator for modulo_1.
package modulo_1_pkg;

  // Sampled input nibble, bit order {A,B,C,D} with A as the MSB.
  typedef logic [3:0] nibble_t;

  // Selectable E function.
  typedef enum logic [1:0] {
    FUNC_PARITY = 2'd0,
    FUNC_MAJ    = 2'd1,
    FUNC_AND    = 2'd2,
    FUNC_OR     = 2'd3
  } func_e;

  // Evaluate the selected function on one nibble.
  // Majority means three or four ones; exactly two ones is not a majority.
  function automatic logic eval_func(input func_e f, input nibble_t n);
    logic [2:0] ones;
    logic       res;
    ones = {2'b00, n[3]} + {2'b00, n[2]} + {2'b00, n[1]} + {2'b00, n[0]};
    case (f)
      FUNC_MAJ: res = (ones >= 3'd3);
      FUNC_AND: res = &n;
      FUNC_OR:  res = |n;
      default:  res = ^n;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/modulo_1_run_counter.sv
// modulo_1_run_counter: saturating count of consecutive pattern matches.
// hit is combinational and reports that the post-edge count reaches MATCH_LEN,
// so the parent can register it and raise F on the MATCH_LEN-th matching edge.
module modulo_1_run_counter #(
  parameter int MATCH_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic match,
  output logic hit
);

  localparam int CW = $clog2(MATCH_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(MATCH_LEN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: increment on a match, hold at MATCH_LEN (never wrap), clear otherwise.
  always_comb begin
    cnt_d = '0;
    if (match) begin
      cnt_d = (cnt_q == LEN) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Count register; reset wins over everything else on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_d == LEN);

endmodule

// File: rtl/modulo_1.sv
// modulo_1: 4-input monitor cell.
//   E: registered logic function of {A,B,C,D} chosen by FUNC (out-of-range -> parity).
//   F: registered flag, high once {A,B,C,D} == PATTERN for MATCH_LEN consecutive edges.
// Build option MODULO1_STICKY_EN: F latches high until rst once it has been set.
module modulo_1
  import modulo_1_pkg::*;
#(
  parameter int          FUNC      = 0,
  parameter logic [3:0]  PATTERN   = 4'b1010,
  parameter int          MATCH_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic E,
  output logic F
);

  localparam func_e FUNC_SEL = (FUNC >= 0 && FUNC <= 3) ? func_e'(FUNC[1:0]) : FUNC_PARITY;

  nibble_t nib;
  logic    match;
  logic    hit;
  logic    e_q, e_d;
  logic    f_q, f_d;

  assign nib   = {A, B, C, D};
  assign match = (nib == PATTERN);

  modulo_1_run_counter #(
    .MATCH_LEN(MATCH_LEN)
  ) u_run_counter (
    .clk  (clk),
    .rst  (rst),
    .match(match),
    .hit  (hit)
  );

  // Next-state of the two output flags.
  always_comb begin
    e_d = eval_func(FUNC_SEL, nib);
`ifdef MODULO1_STICKY_EN
    f_d = hit | f_q;
`else
    f_d = hit;
`endif
  end

  // Output registers; reset clears both flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      e_q <= e_d;
      f_q <= f_d;
    end
  end

  assign E = e_q;
  assign F = f_q;

endmodule

// File: tb/tb_modulo_1.sv
// tb_modulo_1: five modulo_1 instances with different FUNC/PATTERN/MATCH_LEN share
// one stimulus stream; a reference model built from input history checks E and F.
module tb_modulo_1;

  localparam int         N = 5;
  localparam int         FUNC_T [N] = '{0, 1, 2, 3, 7};
  localparam logic [3:0] PAT_T  [N] = '{4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0110};
  localparam int         ML_T   [N] = '{3, 1, 15, 2, 3};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] e_w;
  logic [N-1:0] f_w;

  for (genvar g = 0; g < N; g++) begin : g_dut
    modulo_1 #(
      .FUNC     (FUNC_T[g]),
      .PATTERN  (PAT_T[g]),
      .MATCH_LEN(ML_T[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .A  (a),
      .B  (b),
      .C  (c),
      .D  (d),
      .E  (e_w[g]),
      .F  (f_w[g])
    );
  end

  // scoreboard state
  int         tests = 0;
  int         fails = 0;
  logic [3:0] hist_q[$];
  logic [N-1:0] ever_q = '0;
  logic [1:0] exp_q[$];

  function automatic logic ref_e(input int func, input logic [3:0] n);
    case (func)
      1:       return $countones(n) >= 3;
      2:       return n == 4'hF;
      3:       return n != 4'h0;
      default: return ($countones(n) % 2) == 1;
    endcase
  endfunction

  // driver + check: apply one nibble (and rst) for one edge, then compare all instances
  task automatic step(input logic [3:0] nib, input logic r);
    logic [1:0] exp;
    @(negedge clk);
    {a, b, c, d} = nib;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      hist_q.delete();
      ever_q = '0;
    end else begin
      hist_q.push_back(nib);
      if (hist_q.size() > 20) void'(hist_q.pop_front());
    end
    for (int k = 0; k < N; k++) begin
      logic ee, ff;
      int   run;
      ee  = 1'b0;
      ff  = 1'b0;
      run = 0;
      if (!r) begin
        ee = ref_e(FUNC_T[k], nib);
        for (int i = hist_q.size() - 1; i >= 0; i--) begin
          if (hist_q[i] != PAT_T[k]) break;
          run++;
        end
        ff = (run >= ML_T[k]);
`ifdef MODULO1_STICKY_EN
        ff = ff | ever_q[k];
        ever_q[k] = ff;
`endif
      end
      exp_q.push_back({ee, ff});
      exp = exp_q.pop_front();
      tests++;
      assert (e_w[k] === exp[1]) else begin
        fails++;
        $error("FAIL E[%0d] nib=%b rst=%b observed=%b expected=%b", k, nib, r, e_w[k], exp[1]);
      end
      tests++;
      assert (f_w[k] === exp[0]) else begin
        fails++;
        $error("FAIL F[%0d] nib=%b rst=%b observed=%b expected=%b", k, nib, r, f_w[k], exp[0]);
      end
    end
  endtask

  initial begin
    logic [3:0] nib;
    // reset with all inputs high, then release
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    // E sweep across all nibbles (each instance covers one FUNC)
    for (int n = 0; n < 16; n++) step(4'(n), 1'b0);
    // run detect, then drop on a non-match
    for (int i = 0; i < 5; i++) step(4'b1010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    // broken run
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b0);
    step(4'b0000, 1'b0);
    // reset mid-run
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b0);
    // sticky behaviour (model follows the build mode)
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    // long run for the MATCH_LEN=15 instance, with saturation beyond it
    for (int i = 0; i < 18; i++) step(4'b1010, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b1111, 1'b0);
    // randomized stimulus biased toward the target patterns
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    nib = 4'b1010;
        2, 3:    nib = 4'b0110;
        default: nib = 4'($urandom_range(0, 15));
      endcase
      step(nib, $urandom_range(0, 39) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/modulo_1.md
Name: modulo_1

Overview:
- Small synchronous 4-input logic/monitor block.
- Samples four single-bit inputs A, B, C, D every clock.
- E: registered combinational function of the four bits, selectable by parameter.
- F: pattern-run detector; asserts once the nibble {A,B,C,D} has equalled a programmed pattern for a programmed number of consecutive cycles.
- Used as a leaf status/monitor cell.

Parameters:
- FUNC, 0, E function select: 0 = XOR parity, 1 = majority (at least 3 of 4 bits high), 2 = AND of all 4, 3 = OR of all 4.
- PATTERN, 4'b1010, target nibble, bit order {A,B,C,D} (A is the MSB).
- MATCH_LEN, 3, consecutive matching cycles required to assert F. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  1  data bit 3.
- B  input  1  data bit 2.
- C  input  1  data bit 1.
- D  input  1  data bit 0.
- E  output  1  registered logic function of {A,B,C,D}.
- F  output  1  registered pattern-run flag.

Behaviour:
- Reset:
  - One clock and one reset. Reset is synchronous and active-high: rst high at a rising edge forces E=0, F=0 and run counter=0.
  - rst overrides all other activity on that edge.
- Reset mid-run: the counter clears and F drops on the same edge. Counting restarts from 0 after the first edge with rst low.
- E:
  - At each non-reset edge, E <= f(A,B,C,D) per FUNC.
  - Latency is one cycle; there is no input pipeline register.
  - Majority (FUNC=1) is true for 3 or 4 ones. Two ones gives 0.
  - A FUNC value outside 0..3 behaves as FUNC=0.
- Run counter:
  - Width is $clog2(MATCH_LEN+1).
  - match = ({A,B,C,D} == PATTERN).
  - Per edge: cnt_next = match ? min(cnt+1, MATCH_LEN) : 0. The counter saturates and never wraps.
- F:
  - At each non-reset edge, F <= (cnt_next == MATCH_LEN).
  - F rises on the same edge that samples the MATCH_LEN-th consecutive match.
  - F stays high while matches continue.
  - F falls on the first edge that samples a non-match, unless sticky mode is enabled.
- MATCH_LEN=1: F is the registered match signal.
- Inputs are assumed synchronous to clk. The block contains no synchronizers.
- Handshakes and X-handling: none.

Optional Feature:
- Macro MODULO1_STICKY_EN.
- When defined: once F is set it stays at 1 until rst, regardless of later non-matches. The counter keeps operating normally. E is unaffected.
- When undefined: F follows the non-sticky rule above.

Decomposition:
- Package modulo_1_pkg holds:
  - typedef nibble_t (logic [3:0]).
  - Enum func_e: FUNC_PARITY=0, FUNC_MAJ=1, FUNC_AND=2, FUNC_OR=3.
  - Function eval_func(func_e, nibble_t) returning logic.
- Sub-module modulo_1_run_counter:
  - Parameter MATCH_LEN.
  - Ports clk, rst, match, hit.
  - Contains the saturating counter and the hit = (cnt_next == MATCH_LEN) logic.
  - Top level registers F from hit and adds the sticky logic.

Test Plan:
- Reset: drive {A,B,C,D}=1111 with rst=1 for 2 edges -> E=0, F=0. Release rst; next edge -> E=0 under FUNC=0 (parity of 1111 is 0).
- E function sweep: apply all 16 nibbles, one per cycle, for each FUNC 0..3. Check E one edge later. Examples: 0111 -> parity 1, maj 1, and 0, or 1; 0011 -> maj 0; 0000 -> or 0.
- Run detect (PATTERN=1010, MATCH_LEN=3): apply 1010 ×3 -> F=0, 0, 1 after edges 1, 2, 3. Apply 1010 ×2 more -> F stays 1. Apply 0000 -> F=0 next edge.
- Broken run: sequence 1010, 1010, 0010, 1010, 1010, 1010 -> F first rises after the 6th edge.
- Reset mid-run: 1010 ×2, then rst=1 for 1 edge while still driving 1010, then 1010 ×2 -> F stays 0. A third 1010 after reset -> F=1.
- Sticky (MODULO1_STICKY_EN defined): 1010 ×3 -> F=1. Then 0000 ×4 -> F remains 1. Then rst -> F=0.
